// File: rtl/ed25519_pkg.sv
// Shared widths, clamp constants and FSM state type for the clamped scalar reader.
package ed25519_pkg;
  localparam int unsigned KEY_W    = 512;
  localparam int unsigned SCALAR_W = 256;
  localparam int unsigned PREFIX_W = KEY_W - SCALAR_W;
  localparam int unsigned CNT_W    = 8;

  // A clamped scalar has bits [2:0] cleared and bits [255:254] == 2'b01.
  localparam logic [2:0] CLAMP_LOW_MASK = 3'b000;
  localparam logic [1:0] CLAMP_TOP_BITS = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic clamp_ok(input logic [SCALAR_W-1:0] s);
    return (s[2:0] == CLAMP_LOW_MASK) && (s[SCALAR_W-1:SCALAR_W-2] == CLAMP_TOP_BITS);
  endfunction
endpackage

// File: rtl/scalar_bit_mux.sv
// Selects one scalar bit by index for the streaming output.
module scalar_bit_mux
  import ed25519_pkg::*;
(
  input  logic [SCALAR_W-1:0] scalar_i,
  input  logic [CNT_W-1:0]    sel_i,
  output logic                bit_o
);
  assign bit_o = scalar_i[sel_i];
endmodule

// File: rtl/clamped_scalar_reader.sv
// Captures a clamped Ed25519 secret key, optionally verifies the clamp, exposes
// the prefix and streams scalar bits MSB-first from START_BIT down to bit 0.
// Optional feature: define SCALAR_CLAMP_CHECK_EN to reject badly clamped keys
// (pulsing clamp_err); without it every key is streamed and clamp_err is 0.
module clamped_scalar_reader
  import ed25519_pkg::*;
#(
  parameter int unsigned START_BIT = 254
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_W-1:0]    in_key,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                bit_last,
  input  logic                bit_ready,
  output logic [PREFIX_W-1:0] prefix_out,
  output logic                prefix_valid,
  output logic                done,
  output logic                clamp_err
);
  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PREFIX_W-1:0] prefix_q, prefix_d;
  logic                pvld_q, pvld_d;
  logic                mux_bit;
`ifdef SCALAR_CLAMP_CHECK_EN
  logic                cerr_q, cerr_d;
`endif

  scalar_bit_mux u_mux (
    .scalar_i (key_q[SCALAR_W-1:0]),
    .sel_i    (cnt_q),
    .bit_o    (mux_bit)
  );

  // Next-state and handshake outputs for the capture/check/stream sequence.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    prefix_d  = prefix_q;
    pvld_d    = pvld_q;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
`ifdef SCALAR_CLAMP_CHECK_EN
    cerr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          key_d   = in_key;
          pvld_d  = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
`ifdef SCALAR_CLAMP_CHECK_EN
        if (!clamp_ok(key_q[SCALAR_W-1:0])) begin
          cerr_d  = 1'b1;
          state_d = ST_IDLE;
        end else
`endif
        begin
          prefix_d = key_q[KEY_W-1:SCALAR_W];
          pvld_d   = 1'b1;
          cnt_d    = CNT_W'(START_BIT);
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        bit_valid = 1'b1;
        // Counter stops at 0 rather than wrapping; bit 0 hands off to DONE.
        if (bit_ready) begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any stream in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      cnt_q    <= '0;
      prefix_q <= '0;
      pvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      prefix_q <= prefix_d;
      pvld_q   <= pvld_d;
    end
  end

`ifdef SCALAR_CLAMP_CHECK_EN
  // Registered so the error pulse lands in the cycle after CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cerr_q <= 1'b0;
    else        cerr_q <= cerr_d;
  end
  assign clamp_err = cerr_q;
`else
  assign clamp_err = 1'b0;
`endif

  assign bit_out      = (state_q == ST_STREAM) & mux_bit;
  assign bit_last     = (state_q == ST_STREAM) & (cnt_q == '0);
  assign prefix_out   = prefix_q;
  assign prefix_valid = pvld_q;
endmodule
